control_unit: RTL
=================

# control_unit

Microsequenced control unit for the 16-bit accumulator processor. It fetches 8-bit opcodes from instruction memory, decodes them, and drives the bus-B source select, register load/increment strobes, ALU operation and data-memory write. It sits directly upstream of the bus-B multiplexer and the register bank: every bus transfer in the datapath is commanded from here.

## Interface
Parameters: none.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  leave IDLE and begin fetching at current PC.
- INSTRUCTIONS  in  8  instruction memory output at address PC; combinational read.
- Z_FLAG  in  1  ALU zero flag for the current AC.
- BUS_SELECT  out  4  bus-B source: 0 DRAM data, 1 PC, 2 R1, 3 R2, 4 TR, 5 R, 6 AC, 7 INSTRUCTIONS, 8 AR.
- LOAD  out  7  one-hot register load from bus. Bits: 0 AC, 1 R1, 2 R2, 3 TR, 4 R, 5 AR, 6 PC.
- INC  out  4  increment strobes. Bits: 0 PC, 1 AR, 2 R1, 3 R2.
- ALU_OP  out  3  ALU function code.
- ALU_EN  out  1  AC loads the ALU result (AC op BUS).
- DRAM_WE  out  1  data memory write of BUS at address AR.
- DONE  out  1  processor halted.

## Operation
- Internal 8-bit IR register, reset 0.
- Opcode map:
  - 0x00 NOP.
  - 0x02 STAC: BUS_SELECT=6, DRAM_WE=1.
  - 0x20–0x2F ALU: IR[3] selects operand (0 → BUS_SELECT=2, 1 → 3); ALU_OP=IR[2:0]; ALU_EN=1.
  - 0x30 INCAR, 0x31 INCR1, 0x32 INCR2: INC bit 1/2/3.
  - 0x40 JMP, 0x41 JMPZ: operand byte follows the opcode.
  - 0x80–0xFE MOV: dest=IR[6:4] (LOAD bit index), src=IR[3:0] (BUS_SELECT value).
  - 0xFF HALT.
  - Any other code is NOP. So is MOV with src>8 or dest=7.
- States and transitions:
  - IDLE: outputs 0. START=1 → FETCH.
  - FETCH: BUS_SELECT=7, INC[0]=1, IR ← INSTRUCTIONS → DECODE.
  - DECODE: outputs 0.
    - HALT → HALT.
    - MOV with src=0 → MEM_WAIT.
    - JMP/JMPZ → OPERAND.
    - NOP or illegal → FETCH.
    - Otherwise → EXEC.
  - MEM_WAIT: outputs 0 (covers the 1-cycle synchronous DRAM read latency) → EXEC.
  - EXEC: drive the per-opcode outputs above → FETCH.
  - OPERAND:
    - JMP, or JMPZ with Z_FLAG=1: BUS_SELECT=7, LOAD[6]=1.
    - JMPZ with Z_FLAG=0: INC[0]=1 (skip the operand byte).
    - Then → FETCH.
  - HALT: DONE=1, all other outputs 0. Stays in HALT until RESET; START is ignored.
- At most one LOAD bit is high at any time. LOAD and ALU_EN are never high together.
- START is sampled only in IDLE.

## Timing
- RESET high: next edge gives state=IDLE and IR=0. While RESET is high, all outputs are forced to 0 combinationally, including mid-EXEC; DRAM_WE therefore never pulses during reset.
- Outputs decode from state and IR only. The one exception is OPERAND for JMPZ, where Z_FLAG combinationally selects load vs. increment.
- Cycles from FETCH to the next FETCH:
  - NOP/illegal: 2.
  - Register MOV, ALU, INC, STAC: 3.
  - MOV from DRAM: 4.
  - JMP/JMPZ: 3.
- Datapath registers update on the edge that ends the strobe cycle.
- In FETCH, the PC increment takes effect on the edge that also latches IR.

## Structure
- Package cu_pkg holds:
  - state enum;
  - opcode constants;
  - BUS_SELECT source codes, shared with the bus-B multiplexer;
  - LOAD and INC bit indices.
- Sub-module instr_decoder: combinational IR → instruction class (nop, mov, mov_mem, alu, inc, stac, jmp, jmpz, halt) plus field extraction. control_unit holds the FSM and the output decode.

## Test plan
- Reset, then START pulse:
  - After RESET, all outputs are 0 and the FSM is in IDLE.
  - One START cycle → next cycle BUS_SELECT=7, INC=4'b0001.
  - Then a DECODE cycle with all outputs 0.
- 0xA6 (MOV R2←AC) → EXEC cycle with BUS_SELECT=6, LOAD=7'b0000100, then FETCH. Total 3 cycles.
- 0x80 (MOV AC←DRAM) → DECODE, MEM_WAIT (outputs 0), then EXEC with BUS_SELECT=0, LOAD=7'b0000001. Total 4 cycles.
- 0x2B → EXEC with BUS_SELECT=3, ALU_OP=3'd3, ALU_EN=1, LOAD=0.
- 0x41 (JMPZ):
  - Z_FLAG=0 → OPERAND with INC=4'b0001, LOAD=0.
  - Z_FLAG=1 → OPERAND with BUS_SELECT=7, LOAD=7'b1000000.
- 0xFF (HALT) → DONE=1 held for 10 cycles while START toggles.
- Separate run: RESET asserted during EXEC of 0x02 → DRAM_WE=0 in that same cycle, FSM in IDLE after the next edge.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator-processor control unit: FSM states,
// instruction classes, opcodes, bus-B source codes and strobe bit indices.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_WAIT,
        ST_EXEC,
        ST_OPERAND,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP,
        CL_MOV,
        CL_MOV_MEM,
        CL_ALU,
        CL_INC,
        CL_STAC,
        CL_JMP,
        CL_JMPZ,
        CL_HALT
    } iclass_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_STAC  = 8'h02;
    localparam logic [7:0] OP_INCAR = 8'h30;
    localparam logic [7:0] OP_INCR1 = 8'h31;
    localparam logic [7:0] OP_INCR2 = 8'h32;
    localparam logic [7:0] OP_JMP   = 8'h40;
    localparam logic [7:0] OP_JMPZ  = 8'h41;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    // Bus-B source codes, shared with the bus-B multiplexer
    localparam logic [3:0] SRC_DRAM  = 4'd0;
    localparam logic [3:0] SRC_PC    = 4'd1;
    localparam logic [3:0] SRC_R1    = 4'd2;
    localparam logic [3:0] SRC_R2    = 4'd3;
    localparam logic [3:0] SRC_TR    = 4'd4;
    localparam logic [3:0] SRC_R     = 4'd5;
    localparam logic [3:0] SRC_AC    = 4'd6;
    localparam logic [3:0] SRC_INSTR = 4'd7;
    localparam logic [3:0] SRC_AR    = 4'd8;

    localparam int unsigned LD_AC = 0;
    localparam int unsigned LD_R1 = 1;
    localparam int unsigned LD_R2 = 2;
    localparam int unsigned LD_TR = 3;
    localparam int unsigned LD_R  = 4;
    localparam int unsigned LD_AR = 5;
    localparam int unsigned LD_PC = 6;

    localparam int unsigned INC_PC = 0;
    localparam int unsigned INC_AR = 1;
    localparam int unsigned INC_R1 = 2;
    localparam int unsigned INC_R2 = 3;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit bundle: instruction/flag inputs and datapath command outputs.
interface control_unit_if;
    logic       START;
    logic [7:0] INSTRUCTIONS;
    logic       Z_FLAG;
    logic [3:0] BUS_SELECT;
    logic [6:0] LOAD;
    logic [3:0] INC;
    logic [2:0] ALU_OP;
    logic       ALU_EN;
    logic       DRAM_WE;
    logic       DONE;

    modport master (
        input  START, INSTRUCTIONS, Z_FLAG,
        output BUS_SELECT, LOAD, INC, ALU_OP, ALU_EN, DRAM_WE, DONE
    );

    modport slave (
        output START, INSTRUCTIONS, Z_FLAG,
        input  BUS_SELECT, LOAD, INC, ALU_OP, ALU_EN, DRAM_WE, DONE
    );
endinterface

// File: rtl/control_unit_instr_decoder.sv
// Combinational instruction decoder: classifies IR and extracts the bus source,
// load destination, ALU function and increment-strobe index.
module instr_decoder
    import cu_pkg::*;
(
    input  logic [7:0] ir,
    output iclass_t    iclass,
    output logic [3:0] src,
    output logic [2:0] dest,
    output logic [2:0] alu_op,
    output logic [1:0] inc_sel
);

    always_comb begin
        iclass  = CL_NOP;
        src     = ir[3:0];
        dest    = ir[6:4];
        alu_op  = ir[2:0];
        inc_sel = ir[1:0] + 2'd1;

        if (ir == OP_HALT) begin
            iclass = CL_HALT;
        end else if (ir[7]) begin
            // Sources above AR and destination 7 have no register behind them
            if (ir[3:0] > SRC_AR || ir[6:4] == 3'd7)
                iclass = CL_NOP;
            else if (ir[3:0] == SRC_DRAM)
                iclass = CL_MOV_MEM;
            else
                iclass = CL_MOV;
        end else if (ir[7:4] == 4'h2) begin
            iclass = CL_ALU;
            src    = ir[3] ? SRC_R2 : SRC_R1;
        end else if (ir inside {OP_INCAR, OP_INCR1, OP_INCR2}) begin
            iclass = CL_INC;
        end else if (ir == OP_STAC) begin
            iclass = CL_STAC;
            src    = SRC_AC;
        end else if (ir == OP_JMP) begin
            iclass = CL_JMP;
        end else if (ir == OP_JMPZ) begin
            iclass = CL_JMPZ;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Microsequenced control unit: fetch/decode/execute FSM driving bus-B select,
// register load/increment strobes, ALU control and DRAM write.
module control_unit
    import cu_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    control_unit_if.master bus
);

    state_t     state, state_nxt;
    logic [7:0] ir;

    iclass_t    iclass;
    logic [3:0] src;
    logic [2:0] dest;
    logic [2:0] alu_op;
    logic [1:0] inc_sel;

    logic [3:0] bus_select_c;
    logic [6:0] load_c;
    logic [3:0] inc_c;
    logic [2:0] alu_op_c;
    logic       alu_en_c;
    logic       dram_we_c;
    logic       done_c;

    instr_decoder u_dec (
        .ir      (ir),
        .iclass  (iclass),
        .src     (src),
        .dest    (dest),
        .alu_op  (alu_op),
        .inc_sel (inc_sel)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH)
                ir <= bus.INSTRUCTIONS;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (bus.START) state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (iclass)
                    CL_HALT:         state_nxt = ST_HALT;
                    CL_MOV_MEM:      state_nxt = ST_MEM_WAIT;
                    CL_JMP, CL_JMPZ: state_nxt = ST_OPERAND;
                    CL_NOP:          state_nxt = ST_FETCH;
                    default:         state_nxt = ST_EXEC;
                endcase
            end
            ST_MEM_WAIT: state_nxt = ST_EXEC;
            ST_EXEC:     state_nxt = ST_FETCH;
            ST_OPERAND:  state_nxt = ST_FETCH;
            ST_HALT:     state_nxt = ST_HALT;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Reset gates every strobe combinationally so nothing fires mid-instruction
    always_comb begin
        bus_select_c = '0;
        load_c       = '0;
        inc_c        = '0;
        alu_op_c     = '0;
        alu_en_c     = 1'b0;
        dram_we_c    = 1'b0;
        done_c       = 1'b0;

        if (!RESET) begin
            case (state)
                ST_FETCH: begin
                    bus_select_c  = SRC_INSTR;
                    inc_c[INC_PC] = 1'b1;
                end
                ST_EXEC: begin
                    case (iclass)
                        CL_MOV, CL_MOV_MEM: begin
                            bus_select_c = src;
                            load_c       = 7'd1 << dest;
                        end
                        CL_ALU: begin
                            bus_select_c = src;
                            alu_op_c     = alu_op;
                            alu_en_c     = 1'b1;
                        end
                        CL_INC:  inc_c = 4'd1 << inc_sel;
                        CL_STAC: begin
                            bus_select_c = src;
                            dram_we_c    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_OPERAND: begin
                    if (iclass == CL_JMP || bus.Z_FLAG) begin
                        bus_select_c  = SRC_INSTR;
                        load_c[LD_PC] = 1'b1;
                    end else begin
                        inc_c[INC_PC] = 1'b1;
                    end
                end
                ST_HALT: done_c = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.BUS_SELECT = bus_select_c;
    assign bus.LOAD       = load_c;
    assign bus.INC        = inc_c;
    assign bus.ALU_OP     = alu_op_c;
    assign bus.ALU_EN     = alu_en_c;
    assign bus.DRAM_WE    = dram_we_c;
    assign bus.DONE       = done_c;

endmodule
